// File: rtl/spec_register_alias_table.sv
// rtl/spec_register_alias_table.sv - speculative rename map table with intra-group bypass and flush recovery
module spec_register_alias_table #(
  parameter int DECODE_WIDTH = 2,
  parameter int PHY_REG_NUM  = 64,
  localparam int PW          = $clog2(PHY_REG_NUM)
) (
  input  logic                       clk,
  input  logic                       rst_n,

  input  logic [DECODE_WIDTH-1:0]    valid_i,
  output logic                       ready_o,
  input  logic [DECODE_WIDTH*5-1:0]  src0_i,
  input  logic [DECODE_WIDTH*5-1:0]  src1_i,
  input  logic [DECODE_WIDTH-1:0]    dest_valid_i,
  input  logic [DECODE_WIDTH*5-1:0]  dest_i,
  input  logic [DECODE_WIDTH*PW-1:0] preg_i,

  output logic [DECODE_WIDTH-1:0]    valid_o,
  input  logic                       ready_i,
  output logic [DECODE_WIDTH*PW-1:0] psrc0_o,
  output logic [DECODE_WIDTH*PW-1:0] psrc1_o,
  output logic [DECODE_WIDTH*PW-1:0] pdst_o,
  output logic [DECODE_WIDTH*PW-1:0] ppdst_o,
  output logic [DECODE_WIDTH-1:0]    dest_valid_o,

  input  logic                       flush_i,
  input  logic [32*PW-1:0]           arch_rat_i
);

  typedef enum logic [0:0] {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } state_e;

  state_e state_q;

  // Speculative logical -> physical map
  logic [PW-1:0] table_q [32];

  // Unpacked per-slot views of the incoming group
  logic [4:0]    src0   [DECODE_WIDTH];
  logic [4:0]    src1   [DECODE_WIDTH];
  logic [4:0]    dest   [DECODE_WIDTH];
  logic [PW-1:0] preg   [DECODE_WIDTH];
  logic [DECODE_WIDTH-1:0] dv;

  // Renamed results for the incoming group, loaded into the output stage on accept
  logic [PW-1:0] psrc0_d [DECODE_WIDTH];
  logic [PW-1:0] psrc1_d [DECODE_WIDTH];
  logic [PW-1:0] ppdst_d [DECODE_WIDTH];

  // Output stage registers
  logic [DECODE_WIDTH-1:0]    valid_q;
  logic [DECODE_WIDTH-1:0]    dest_valid_q;
  logic [DECODE_WIDTH*PW-1:0] psrc0_q;
  logic [DECODE_WIDTH*PW-1:0] psrc1_q;
  logic [DECODE_WIDTH*PW-1:0] pdst_q;
  logic [DECODE_WIDTH*PW-1:0] ppdst_q;

  logic accept;

  // Output-stage space is available when empty or draining this cycle; flush blocks intake
  assign ready_o = (state_q == NORMAL) && !flush_i && (!(|valid_q) || ready_i);
  assign accept  = (|valid_i) && ready_o;

  // Slice the flat input buses and form effective destination valids (r0 never remapped)
  always_comb begin
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      src0[i] = src0_i[i*5 +: 5];
      src1[i] = src1_i[i*5 +: 5];
      dest[i] = dest_i[i*5 +: 5];
      preg[i] = preg_i[i*PW +: PW];
      dv[i]   = dest_valid_i[i] & valid_i[i] & (dest_i[i*5 +: 5] != 5'd0);
    end
  end

  // Table lookup with bypass from the youngest earlier same-group writer
  always_comb begin
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      psrc0_d[i] = table_q[src0[i]];
      psrc1_d[i] = table_q[src1[i]];
      ppdst_d[i] = table_q[dest[i]];
      // Ascending scan: a later (younger) matching slot overrides an earlier one
      for (int j = 0; j < DECODE_WIDTH; j++) begin
        if (j < i && dv[j]) begin
          if (dest[j] == src0[i]) psrc0_d[i] = preg[j];
          if (dest[j] == src1[i]) psrc1_d[i] = preg[j];
          if (dest[j] == dest[i]) ppdst_d[i] = preg[j];
        end
      end
    end
  end

  // Map table: restore from the committed map in RECOVER, else record accepted destinations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        table_q[r] <= '0;
      end
    end else if (state_q == RECOVER) begin
      // r0 stays pinned to physical register 0 regardless of the committed image
      table_q[0] <= '0;
      for (int r = 1; r < 32; r++) begin
        table_q[r] <= arch_rat_i[r*PW +: PW];
      end
    end else if (accept) begin
      // Ascending slot order so the highest slot wins on a same-register WAW
      for (int i = 0; i < DECODE_WIDTH; i++) begin
        if (dv[i]) begin
          table_q[dest[i]] <= preg[i];
        end
      end
    end
  end

  // Recovery FSM and registered output stage; flush outranks accept and ready_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= NORMAL;
      valid_q      <= '0;
      dest_valid_q <= '0;
      psrc0_q      <= '0;
      psrc1_q      <= '0;
      pdst_q       <= '0;
      ppdst_q      <= '0;
    end else begin
      case (state_q)
        NORMAL: begin
          if (flush_i) begin
            state_q      <= RECOVER;
            valid_q      <= '0;
            dest_valid_q <= '0;
            psrc0_q      <= '0;
            psrc1_q      <= '0;
            pdst_q       <= '0;
            ppdst_q      <= '0;
          end else if (accept) begin
            valid_q      <= valid_i;
            dest_valid_q <= dv;
            for (int i = 0; i < DECODE_WIDTH; i++) begin
              psrc0_q[i*PW +: PW] <= psrc0_d[i];
              psrc1_q[i*PW +: PW] <= psrc1_d[i];
              pdst_q[i*PW +: PW]  <= preg[i];
              ppdst_q[i*PW +: PW] <= ppdst_d[i];
            end
          end else if (ready_i) begin
            // Group consumed downstream with nothing to replace it
            valid_q      <= '0;
            dest_valid_q <= '0;
            psrc0_q      <= '0;
            psrc1_q      <= '0;
            pdst_q       <= '0;
            ppdst_q      <= '0;
          end
        end
        RECOVER: begin
          valid_q      <= '0;
          dest_valid_q <= '0;
          // A repeated flush keeps recovering for one more cycle
          if (!flush_i) begin
            state_q <= NORMAL;
          end
        end
        default: begin
          state_q <= NORMAL;
        end
      endcase
    end
  end

  assign valid_o      = valid_q;
  assign dest_valid_o = dest_valid_q;
  assign psrc0_o      = psrc0_q;
  assign psrc1_o      = psrc1_q;
  assign pdst_o       = pdst_q;
  assign ppdst_o      = ppdst_q;

endmodule

// File: tb/tb_spec_register_alias_table.sv
// tb/tb_spec_register_alias_table.sv - self-checking bench for spec_register_alias_table
module tb_spec_register_alias_table;

  localparam int DW = 2;
  localparam int PW = 6;

  logic           clk;
  logic           rst_n;
  logic [DW-1:0]  valid_i;
  logic           ready_o;
  logic [DW*5-1:0]  src0_i;
  logic [DW*5-1:0]  src1_i;
  logic [DW-1:0]    dest_valid_i;
  logic [DW*5-1:0]  dest_i;
  logic [DW*PW-1:0] preg_i;
  logic [DW-1:0]    valid_o;
  logic             ready_i;
  logic [DW*PW-1:0] psrc0_o;
  logic [DW*PW-1:0] psrc1_o;
  logic [DW*PW-1:0] pdst_o;
  logic [DW*PW-1:0] ppdst_o;
  logic [DW-1:0]    dest_valid_o;
  logic             flush_i;
  logic [32*PW-1:0] arch_rat_i;

  spec_register_alias_table #(.DECODE_WIDTH(DW), .PHY_REG_NUM(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .src0_i       (src0_i),
    .src1_i       (src1_i),
    .dest_valid_i (dest_valid_i),
    .dest_i       (dest_i),
    .preg_i       (preg_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .psrc0_o      (psrc0_o),
    .psrc1_o      (psrc1_o),
    .pdst_o       (pdst_o),
    .ppdst_o      (ppdst_o),
    .dest_valid_o (dest_valid_o),
    .flush_i      (flush_i),
    .arch_rat_i   (arch_rat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] dvi;
    logic [4:0] s0 [2];
    logic [4:0] s1 [2];
    logic [4:0] d  [2];
    logic [5:0] p  [2];
    logic [5:0] e_ps0 [2];
    logic [5:0] e_ps1 [2];
    logic [5:0] e_ppd [2];
    logic [1:0] e_dvo;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t sb_q[$];
  vec_t vecs[7];

  function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] dvi,
                              input int s0a, input int s1a, input int da, input int pa,
                              input int s0b, input int s1b, input int db, input int pb,
                              input int e0a, input int e1a, input int epa,
                              input int e0b, input int e1b, input int epb,
                              input logic [1:0] edvo);
    vec_t v;
    v.valid = valid;  v.dvi = dvi;
    v.s0[0] = 5'(s0a); v.s1[0] = 5'(s1a); v.d[0] = 5'(da); v.p[0] = 6'(pa);
    v.s0[1] = 5'(s0b); v.s1[1] = 5'(s1b); v.d[1] = 5'(db); v.p[1] = 6'(pb);
    v.e_ps0[0] = 6'(e0a); v.e_ps1[0] = 6'(e1a); v.e_ppd[0] = 6'(epa);
    v.e_ps0[1] = 6'(e0b); v.e_ps1[1] = 6'(e1b); v.e_ppd[1] = 6'(epb);
    v.e_dvo = edvo;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    valid_i      = v.valid;
    dest_valid_i = v.dvi;
    for (int k = 0; k < DW; k++) begin
      src0_i[k*5 +: 5]  = v.s0[k];
      src1_i[k*5 +: 5]  = v.s1[k];
      dest_i[k*5 +: 5]  = v.d[k];
      preg_i[k*PW +: PW] = v.p[k];
    end
  endtask

  task automatic compare_out(input vec_t e);
    chk("valid_o", int'(valid_o), int'(e.valid));
    chk("dest_valid_o", int'(dest_valid_o), int'(e.e_dvo));
    for (int k = 0; k < DW; k++) begin
      if (e.valid[k]) begin
        chk($sformatf("psrc0_o[%0d]", k), int'(psrc0_o[k*PW +: PW]), int'(e.e_ps0[k]));
        chk($sformatf("psrc1_o[%0d]", k), int'(psrc1_o[k*PW +: PW]), int'(e.e_ps1[k]));
        chk($sformatf("pdst_o[%0d]", k),  int'(pdst_o[k*PW +: PW]),  int'(e.p[k]));
        chk($sformatf("ppdst_o[%0d]", k), int'(ppdst_o[k*PW +: PW]), int'(e.e_ppd[k]));
      end
    end
  endtask

  // Pop the oldest expected group and compare it with the output stage
  task automatic pop_cmp();
    vec_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      compare_out(e);
    end
  endtask

  // One cycle: drive at negedge, check ready_o before the edge, compare outputs after it
  task automatic step(input vec_t v, input logic exp_ready);
    logic acc;
    @(negedge clk);
    apply(v);
    #4;
    chk("ready_o", int'(ready_o), int'(exp_ready));
    acc = (|valid_i) && ready_o;
    if (acc) sb_q.push_back(v);
    @(posedge clk);
    #1;
    if (acc) pop_cmp();
  endtask

  task automatic set_arch(input int offs);
    for (int r = 0; r < 32; r++) arch_rat_i[r*PW +: PW] = 6'(r + offs);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle;
    vec_t vb1, vb2, vf, vr, va, vz;
    logic [1:0] exp_fl [4];
    logic       exp_rd [4];

    idle = mk(2'b00, 2'b00, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 2'b00);

    // Directed vectors, expectations worked out by hand from the rename rules
    vecs[0] = mk(2'b01, 2'b01, 5,0,3,40,  0,0,0,0,   0,0,0,     0,0,0,     2'b01);
    vecs[1] = mk(2'b01, 2'b00, 3,5,0,0,   0,0,0,0,   40,0,0,    0,0,0,     2'b00);
    vecs[2] = mk(2'b11, 2'b11, 3,0,7,12,  3,7,7,13,  40,0,0,    40,12,12,  2'b11);
    vecs[3] = mk(2'b11, 2'b11, 7,3,0,50,  0,7,9,20,  13,40,0,   0,13,0,    2'b10);
    vecs[4] = mk(2'b11, 2'b01, 9,0,9,21,  9,9,3,22,  20,0,20,   21,21,40,  2'b01);
    vecs[5] = mk(2'b10, 2'b11, 0,0,9,30,  9,3,3,23,  0,0,0,     21,40,40,  2'b10);
    vecs[6] = mk(2'b11, 2'b00, 3,9,0,0,   0,3,0,0,   23,21,0,   0,23,0,    2'b00);

    rst_n = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    set_arch(0);
    apply(idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset valid_o", int'(valid_o), 0);
    chk("reset dest_valid_o", int'(dest_valid_o), 0);
    chk("reset psrc0_o", int'(psrc0_o), 0);
    chk("reset ppdst_o", int'(ppdst_o), 0);
    chk("reset ready_o", int'(ready_o), 1);

    for (int i = 0; i < 7; i++) step(vecs[i], 1'b1);
    step(idle, 1'b1);

    // Backpressure: stalled group holds, next group accepted in the cycle ready_i rises
    ready_i = 1'b0;
    vb1 = mk(2'b01, 2'b01, 7,0,5,33, 0,0,0,0, 13,0,0, 0,0,0, 2'b01);
    vb2 = mk(2'b01, 2'b01, 5,0,6,34, 0,0,0,0, 33,0,0, 0,0,0, 2'b01);
    step(vb1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      apply(vb2);
      #4;
      chk("stall ready_o", int'(ready_o), 0);
      @(posedge clk);
      #1;
      chk("stall valid_o", int'(valid_o), 1);
      chk("stall psrc0_o", int'(psrc0_o[0 +: PW]), 13);
      chk("stall pdst_o", int'(pdst_o[0 +: PW]), 33);
    end
    @(negedge clk);
    ready_i = 1'b1;
    #4;
    chk("release ready_o", int'(ready_o), 1);
    if ((|valid_i) && ready_o) sb_q.push_back(vb2);
    @(posedge clk);
    #1;
    pop_cmp();

    // Flush restore: table taken from arch_rat_i of cycle t+1, not t or t+2
    vf = mk(2'b01, 2'b01, 0,0,4,60, 0,0,0,0, 0,0,0, 0,0,0, 2'b01);
    @(negedge clk);
    ready_i = 1'b0;
    flush_i = 1'b1;
    set_arch(1);
    apply(vf);
    #4;
    chk("flush t ready_o", int'(ready_o), 0);
    @(posedge clk);
    #1;
    chk("flush t valid_o", int'(valid_o), 0);
    @(negedge clk);
    flush_i = 1'b0;
    set_arch(32);
    #4;
    chk("flush t+1 ready_o", int'(ready_o), 0);
    @(posedge clk);
    #1;
    chk("flush t+1 valid_o", int'(valid_o), 0);
    set_arch(5);
    ready_i = 1'b1;
    vr = mk(2'b01, 2'b00, 4,6,9,0, 0,0,0,0, 36,38,41, 0,0,0, 2'b00);
    step(vr, 1'b1);
    set_arch(32);

    // Back-to-back flush holds RECOVER one extra cycle
    exp_fl = '{2'b01, 2'b01, 2'b00, 2'b00};
    exp_rd = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      apply(idle);
      flush_i = exp_fl[c][0];
      #4;
      chk($sformatf("b2b ready_o c%0d", c), int'(ready_o), int'(exp_rd[c]));
      @(posedge clk);
    end
    @(negedge clk);
    flush_i = 1'b0;

    // Reset mid-operation clears outputs immediately and empties the table
    va = mk(2'b01, 2'b01, 8,0,3,44, 0,0,0,0, 40,0,35, 0,0,0, 2'b01);
    step(va, 1'b1);
    @(negedge clk);
    apply(idle);
    rst_n = 1'b0;
    #1;
    chk("async reset valid_o", int'(valid_o), 0);
    chk("async reset pdst_o", int'(pdst_o), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vz = mk(2'b01, 2'b00, 3,8,0,0, 0,0,0,0, 0,0,0, 0,0,0, 2'b00);
    step(vz, 1'b1);

    chk("scoreboard drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
